// File: rtl/awg_cmd_parser.sv
// AWG command parser: turns the UART byte stream into per-channel wave-state and frequency registers.
// Optional idle-byte timeout for partial commands is enabled by defining CMD_TIMEOUT_EN.
module awg_cmd_parser #(
  parameter int NUM_CH         = 2,
  parameter int STATE_W        = 5,
  parameter int FREQ_W         = 32,
  parameter int MAX_DIGITS     = 10,
  parameter int DEFAULT_STATE  = 3,
  parameter int FREQ_DEFAULT   = 0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic [NUM_CH*STATE_W-1:0] wave_sel,
  output logic [NUM_CH*FREQ_W-1:0]  freq_word,
  output logic [NUM_CH-1:0]         upd,
  output logic                      err,
  output logic                      busy
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(MAX_DIGITS + 2);
  localparam int ACC_W = FREQ_W + 4;

  typedef enum logic [2:0] {S_IDLE, S_W_CH, S_W_WAVE, S_F_CH, S_F_DIG} state_t;

  function automatic logic is_wave(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h34);
  endfunction

  // '1'..'4' map to 0..3; '0' selects code 10.
  function automatic logic [STATE_W-1:0] wave_code(input logic [7:0] b);
    if (b == 8'h30) return STATE_W'(10);
    return STATE_W'(b - 8'h31);
  endfunction

  function automatic logic is_chan(input logic [7:0] b);
    return (int'(b) >= 32'h30) && (int'(b) < 32'h30 + NUM_CH);
  endfunction

  function automatic logic is_dec(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  state_t                           state_q;
  logic [NUM_CH-1:0][STATE_W-1:0]   wave_sel_q;
  logic [NUM_CH-1:0][FREQ_W-1:0]    freq_q;
  logic [NUM_CH-1:0]                upd_q;
  logic                             err_q;
  logic [FREQ_W-1:0]                acc_q;
  logic [CNT_W-1:0]                 cnt_q;
  logic [CH_W-1:0]                  ch_q;

  logic [ACC_W-1:0] acc_ext;
  logic [ACC_W-1:0] acc_mac;
  logic             acc_ovf;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_over;

  // acc*10 + d done as shifts so the product cannot wrap before the range check.
  assign acc_ext  = {4'b0000, acc_q};
  assign acc_mac  = (acc_ext << 3) + (acc_ext << 1) + ACC_W'(rx_data[3:0]);
  assign acc_ovf  = |acc_mac[ACC_W-1:FREQ_W];
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign cnt_over = int'(cnt_inc) > MAX_DIGITS;

`ifdef CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wave_sel_q <= {NUM_CH{STATE_W'(DEFAULT_STATE)}};
      freq_q     <= {NUM_CH{FREQ_W'(FREQ_DEFAULT)}};
      upd_q      <= '0;
      err_q      <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ch_q       <= '0;
`ifdef CMD_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      upd_q <= '0;
      err_q <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      // Timeout only fires on byte-free cycles, so it never collides with the parser below.
      if (state_q == S_IDLE || rx_valid) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        to_cnt_q <= '0;
        err_q    <= 1'b1;
        state_q  <= S_IDLE;
      end else begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
`endif
      if (rx_valid) begin
        case (state_q)
          S_IDLE: begin
            if (is_wave(rx_data)) begin
              wave_sel_q <= {NUM_CH{wave_code(rx_data)}};
              upd_q      <= '1;
            end else if (rx_data == 8'h57) begin
              state_q <= S_W_CH;
            end else if (rx_data == 8'h46) begin
              state_q <= S_F_CH;
              acc_q   <= '0;
              cnt_q   <= '0;
            end else if (rx_data != 8'h0D && rx_data != 8'h0A) begin
              err_q <= 1'b1;
            end
          end
          S_W_CH, S_F_CH: begin
            if (is_chan(rx_data)) begin
              ch_q    <= rx_data[CH_W-1:0];
              state_q <= (state_q == S_W_CH) ? S_W_WAVE : S_F_DIG;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end
          end
          S_W_WAVE: begin
            if (is_wave(rx_data)) begin
              wave_sel_q[ch_q] <= wave_code(rx_data);
              upd_q[ch_q]      <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
          S_F_DIG: begin
            if (is_dec(rx_data)) begin
              if (acc_ovf || cnt_over) begin
                err_q   <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                acc_q <= acc_mac[FREQ_W-1:0];
                cnt_q <= cnt_inc;
              end
            end else if (rx_data == 8'h0D && cnt_q != '0) begin
              freq_q[ch_q] <= acc_q;
              upd_q[ch_q]  <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign wave_sel  = wave_sel_q;
  assign freq_word = freq_q;
  assign upd       = upd_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/awg_cmd_parser.md
Name: awg_cmd_parser

Overview:
- Multi-channel successor to the single-byte waveform state selector in the AWG command path.
- Parses the UART receive byte stream into three command types:
  - legacy single-digit waveform broadcast;
  - per-channel waveform select;
  - per-channel decimal frequency tuning word.
- Drives the wave-state and frequency registers consumed by the per-channel DDS/waveform generators.

Parameters:
- NUM_CH, 2, number of output channels (1..10; channel addressed by ASCII digit).
- STATE_W, 5, width of each channel's wave-state code.
- FREQ_W, 32, width of each channel's frequency tuning word.
- MAX_DIGITS, 10, maximum decimal digits accepted in an F command.
- DEFAULT_STATE, 3, reset wave-state code of every channel.
- FREQ_DEFAULT, 0, reset frequency word of every channel.
- TIMEOUT_CYCLES, 1000000, idle-byte timeout; used only with CMD_TIMEOUT_EN.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, asynchronous active-high reset.
- rx_data, input, 8, received byte; valid only when rx_valid is 1.
- rx_valid, input, 1, one-cycle strobe per received byte.
- wave_sel, output, NUM_CH*STATE_W, packed wave-state codes; channel n occupies bits [n*STATE_W +: STATE_W].
- freq_word, output, NUM_CH*FREQ_W, packed tuning words; channel n occupies bits [n*FREQ_W +: FREQ_W].
- upd, output, NUM_CH, per-channel one-cycle pulse: that channel's wave_sel or freq_word just changed.
- err, output, 1, one-cycle pulse: command rejected.
- busy, output, 1, high while a multi-byte command is in progress (FSM not in IDLE).

Behaviour:
- Reset (async assert, sync release):
  - FSM to IDLE; all wave_sel fields = DEFAULT_STATE; all freq_word fields = FREQ_DEFAULT.
  - upd = 0, err = 0, busy = 0; accumulator and digit count cleared.
  - Reset mid-command discards the partial command.
- The FSM advances only on cycles with rx_valid = 1. It holds on all other cycles, except for the timeout (see Optional Feature).
- Wave digit map:
  - '1' (0x31) -> 0; '2' -> 1; '3' -> 2; '4' -> 3; '0' (0x30) -> 10.
  - Any other byte in a wave-digit position is invalid.
- Channel digit: 0x30 + n with n < NUM_CH is valid; anything else is invalid.
- States and transitions:
  - IDLE:
    - A wave digit loads all channels with the mapped code (legacy broadcast); upd = all ones.
    - 'W' (0x57) -> W_CH.
    - 'F' (0x46) -> F_CH; accumulator = 0; digit count = 0.
    - 0x0D and 0x0A are ignored silently.
    - Any other byte gives an err pulse; FSM stays in IDLE.
  - W_CH: valid channel digit -> latch ch, go to W_WAVE.
  - W_WAVE: valid wave digit -> wave_sel[ch] = code, upd[ch] pulse, go to IDLE.
  - F_CH: valid channel digit -> latch ch, go to F_DIG.
  - F_DIG, on an ASCII digit '0'..'9':
    - acc = acc*10 + d, computed at FREQ_W+4 bits; digit count increments.
    - Result exceeding 2^FREQ_W-1 is an error.
    - Digit count exceeding MAX_DIGITS is an error.
  - F_DIG, on 0x0D:
    - Digit count 0 is an error.
    - Otherwise freq_word[ch] = acc, upd[ch] pulse, go to IDLE.
- Any invalid byte in a non-IDLE state:
  - err pulse; FSM to IDLE; no output register changes.
  - The offending byte is consumed, not reinterpreted as a new command.
- Timing:
  - Output registers change on the same edge that samples the final byte.
  - upd/err are high for exactly the one cycle following that edge.
  - Back-to-back rx_valid on consecutive cycles must be supported with no byte loss.
- A rewrite with an identical value still pulses upd.
- Outputs other than upd/err hold their value indefinitely between commands.

Optional Feature:
- Macro CMD_TIMEOUT_EN.
- Defined:
  - A counter clears on every rx_valid and counts while FSM is not in IDLE.
  - When it reaches TIMEOUT_CYCLES: err pulse, FSM to IDLE, partial command discarded.
  - The counter is held at 0 in IDLE.
- Undefined:
  - No counter logic; a partial command waits forever for the next byte.
  - TIMEOUT_CYCLES is unused.

Test Plan:
- Reset, no bytes -> wave_sel fields all 3, freq_word all 0, busy 0, upd/err never pulse.
- Byte '2' in IDLE (NUM_CH=2) -> both fields = 1; upd = 2'b11 for one cycle; then byte '0' -> both = 10.
- Bytes "W","1","4", consecutive cycles -> busy high after 'W' through '1'; ch1 = 3; ch0 unchanged; upd = 2'b10 one cycle.
- Bytes "F","0","1","0","0","0",0x0D -> freq_word ch0 = 1000, upd[0] pulse.
- Bytes "F","1","4294967296",0x0D -> err on the final '6', FSM IDLE, freq ch1 unchanged.
- Bytes "F","1",0x0D -> err, no update.
- Error cases:
  - "W","5" -> err (invalid channel).
  - "W","0","9" -> err, ch0 unchanged.
  - 'Z' in IDLE -> err.
  - 0x0A in IDLE -> no err.
- CMD_TIMEOUT_EN with TIMEOUT_CYCLES=8:
  - "W", then 8 idle cycles -> err, busy 0.
  - A following "1" is treated as a legacy broadcast, setting all channels to 0.
- rst asserted after "F","0","1","2" -> outputs at reset values immediately; subsequent 0x0D is ignored silently.
